idu_decode: RTL



---
 rtl/idu_pkg.sv | 71 +++++++
 rtl/idu_scoreboard.sv | 45 ++++
 rtl/idu_decode.sv | 98 +++++++++
 3 files changed

// File: rtl/idu_pkg.sv
// Shared decode types: RV32I opcodes, operation classes, immediate formats
// and width defaults common to the decode stage and the register file.
package idu_pkg;

   localparam int DEF_REG_ADDR_WIDTH = 5;
   localparam int DEF_REG_NUM        = 32;
   localparam int DEF_REG_WIDTH      = 32;
   localparam int DEF_PC_WIDTH       = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL
   } op_class_t;

   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_fmt_t;

   typedef struct packed {
      op_class_t op;
      imm_fmt_t  fmt;
      logic      uses_rs1;
      logic      uses_rs2;
      logic      writes_rd;
   } dec_t;

   function automatic dec_t decode_op(input logic [6:0] opcode);
      dec_t d;
      d.op        = ILLEGAL;
      d.fmt       = IMM_NONE;
      d.uses_rs1  = 1'b0;
      d.uses_rs2  = 1'b0;
      d.writes_rd = 1'b0;
      case (opcode)
         OPC_OP:     begin d.op = ALU_R;  d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.writes_rd = 1'b1; end
         OPC_OP_IMM: begin d.op = ALU_I;  d.fmt = IMM_I; d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; end
         OPC_LOAD:   begin d.op = LOAD;   d.fmt = IMM_I; d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; end
         OPC_STORE:  begin d.op = STORE;  d.fmt = IMM_S; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
         OPC_BRANCH: begin d.op = BRANCH; d.fmt = IMM_B; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
         OPC_JAL:    begin d.op = JAL;    d.fmt = IMM_J; d.writes_rd = 1'b1; end
         OPC_JALR:   begin d.op = JALR;   d.fmt = IMM_I; d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; end
         OPC_LUI:    begin d.op = LUI;    d.fmt = IMM_U; d.writes_rd = 1'b1; end
         OPC_AUIPC:  begin d.op = AUIPC;  d.fmt = IMM_U; d.writes_rd = 1'b1; end
         default:    d.op = ILLEGAL;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_fmt_t fmt);
      logic [31:0] imm;
      case (fmt)
         IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm = {inst[31:12], 12'b0};
         IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/idu_scoreboard.sv
// Per-register busy bits for RAW hazard tracking; x0 is never busy.
module idu_scoreboard import idu_pkg::*; #(
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
   parameter int REG_NUM        = DEF_REG_NUM
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      set_en,
   input  logic [REG_ADDR_WIDTH-1:0] set_addr,
   input  logic                      clr_en,
   input  logic [REG_ADDR_WIDTH-1:0] clr_addr,
   input  logic [REG_ADDR_WIDTH-1:0] q1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] q2_addr,
   output logic                      q1_busy,
   output logic                      q2_busy
);

   logic [REG_NUM-1:1] busy_q;
   logic [REG_NUM-1:1] set_vec;
   logic [REG_NUM-1:1] clr_vec;
   logic [REG_NUM-1:0] look;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int i = 1; i < REG_NUM; i++) begin
         set_vec[i] = set_en & (set_addr == REG_ADDR_WIDTH'(i));
         clr_vec[i] = clr_en & (clr_addr == REG_ADDR_WIDTH'(i));
      end
   end

   // Bits being cleared this cycle still read busy; bits being set already read busy.
   assign look    = {busy_q | set_vec, 1'b0};
   assign q1_busy = look[q1_addr];
   assign q2_busy = look[q2_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= (busy_q & ~clr_vec) | set_vec;
      end
   end

endmodule

// File: rtl/idu_decode.sv
// Decode stage: one-entry decode register, register file read addressing
// and scoreboard-gated issue to EXU.
module idu_decode import idu_pkg::*; #(
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
   parameter int REG_NUM        = DEF_REG_NUM,
   parameter int REG_WIDTH      = DEF_REG_WIDTH,
   parameter int PC_WIDTH       = DEF_PC_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ifu_valid,
   output logic                      ifu_ready,
   input  logic [31:0]               ifu_inst,
   input  logic [PC_WIDTH-1:0]       ifu_pc,
   output logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr,
   output logic [REG_ADDR_WIDTH-1:0] rf_rs2_addr,
   input  logic                      rf_rd_we,
   input  logic [REG_ADDR_WIDTH-1:0] rf_rd_addr,
   input  logic                      exu_flush,
   input  logic                      exu_ready,
   output logic                      idu_valid,
   output logic [PC_WIDTH-1:0]       idu_pc,
   output op_class_t                 idu_op,
   output logic [2:0]                idu_funct3,
   output logic                      idu_funct7b5,
   output logic [REG_ADDR_WIDTH-1:0] idu_rd_addr,
   output logic [REG_WIDTH-1:0]      idu_imm,
   output logic                      idu_illegal
);

   dec_t                      dec;
   logic                      d_valid, fresh_q, d_valid_next;
   logic                      accept, issue, hz, rs1_busy, rs2_busy;
   logic [REG_ADDR_WIDTH-1:0] rs1_q, rs2_q, in_rs1, in_rs2;

   assign dec    = decode_op(ifu_inst[6:0]);
   assign in_rs1 = dec.uses_rs1 ? ifu_inst[19:15] : '0;
   assign in_rs2 = dec.uses_rs2 ? ifu_inst[24:20] : '0;

   assign idu_valid = d_valid & fresh_q;
   assign issue     = idu_valid & exu_ready;
   assign ifu_ready = ~d_valid | issue;
   assign accept    = ifu_valid & ifu_ready & ~exu_flush;

   // Unused sources read x0, so the hazard lookup needs no separate use flags.
   assign rf_rs1_addr = accept ? in_rs1 : rs1_q;
   assign rf_rs2_addr = accept ? in_rs2 : rs2_q;

   assign d_valid_next = ~exu_flush & (accept | (d_valid & ~issue));
   assign hz           = rs1_busy | rs2_busy;

   idu_scoreboard #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .REG_NUM        (REG_NUM)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (issue & ~exu_flush),
      .set_addr (idu_rd_addr),
      .clr_en   (rf_rd_we),
      .clr_addr (rf_rd_addr),
      .q1_addr  (rf_rs1_addr),
      .q2_addr  (rf_rs2_addr),
      .q1_busy  (rs1_busy),
      .q2_busy  (rs2_busy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_valid      <= 1'b0;
         fresh_q      <= 1'b0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         idu_pc       <= '0;
         idu_op       <= ALU_R;
         idu_funct3   <= '0;
         idu_funct7b5 <= 1'b0;
         idu_rd_addr  <= '0;
         idu_imm      <= '0;
         idu_illegal  <= 1'b0;
      end else begin
         d_valid <= d_valid_next;
         fresh_q <= d_valid_next & ~hz;
         if (accept) begin
            rs1_q        <= in_rs1;
            rs2_q        <= in_rs2;
            idu_pc       <= ifu_pc;
            idu_op       <= dec.op;
            idu_funct3   <= ifu_inst[14:12];
            idu_funct7b5 <= ifu_inst[30];
            idu_rd_addr  <= dec.writes_rd ? ifu_inst[11:7] : '0;
            idu_imm      <= gen_imm(ifu_inst, dec.fmt);
            idu_illegal  <= (dec.op == ILLEGAL);
         end
      end
   end

endmodule
